param_serializer: RTL and testbench

PARAM_SERIALIZER -- requirements
Module: param_serializer

---
 rtl/param_serializer.sv | 98 +++++++++
 tb/tb_param_serializer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_serializer.sv
// Parallel-to-serial shifter with parity, tick-paced bit advance
// and a one-cycle done pulse that allows back-to-back loads.
module param_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter bit LSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b1,
    parameter bit PAR_ODD    = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  data_valid,
    output logic                  ready,
    input  logic                  tick,
    output logic                  ser_data,
    output logic                  ser_busy,
    output logic                  ser_done,
    output logic                  par_bit
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  ser_q, ser_d;
    logic                  done_q, done_d;
    logic                  par_q, par_d;

    // The outgoing bit always sits at the exit end of the shift register.
    assign shifted = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        ser_d   = ser_q;
        done_d  = 1'b0;
        par_d   = par_q;
        unique case (state_q)
            IDLE: begin
                if (data_valid) begin
                    shreg_d = P_DATA;
                    cnt_d   = '0;
                    ser_d   = LSB_FIRST ? P_DATA[0]
                                        : P_DATA[DATA_WIDTH-1];
                    par_d   = (^P_DATA) ^ PAR_ODD;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (cnt_q == LAST) begin
                        ser_d   = IDLE_LEVEL;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        shreg_d = shifted;
                        ser_d   = LSB_FIRST ? shifted[0]
                                            : shifted[DATA_WIDTH-1];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            ser_q   <= IDLE_LEVEL;
            done_q  <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
            par_q   <= par_d;
        end
    end

    assign ready    = (state_q == IDLE);
    assign ser_busy = (state_q == SHIFT);
    assign ser_data = ser_q;
    assign ser_done = done_q;
    assign par_bit  = par_q;

endmodule

// File: tb/tb_param_serializer.sv
// Directed bench for param_serializer: three parameterisations
// sharing one clock and reset.
module tb_param_serializer;

    logic CLK;
    logic RST;

    logic [7:0] pd_a;
    logic       dv_a, tk_a;
    logic       rdy_a, sd_a, bsy_a, dn_a, par_a;

    logic [7:0] pd_b;
    logic       dv_b, tk_b;
    logic       rdy_b, sd_b, bsy_b, dn_b, par_b;

    logic [4:0] pd_c;
    logic       dv_c, tk_c;
    logic       rdy_c, sd_c, bsy_c, dn_c, par_c;

    int nvec = 0;
    int nerr = 0;

    param_serializer u_msb (
        .CLK(CLK), .RST(RST), .P_DATA(pd_a), .data_valid(dv_a),
        .ready(rdy_a), .tick(tk_a), .ser_data(sd_a),
        .ser_busy(bsy_a), .ser_done(dn_a), .par_bit(par_a)
    );

    param_serializer #(.LSB_FIRST(1'b1)) u_lsb (
        .CLK(CLK), .RST(RST), .P_DATA(pd_b), .data_valid(dv_b),
        .ready(rdy_b), .tick(tk_b), .ser_data(sd_b),
        .ser_busy(bsy_b), .ser_done(dn_b), .par_bit(par_b)
    );

    param_serializer #(.DATA_WIDTH(5), .PAR_ODD(1'b1)) u_w5 (
        .CLK(CLK), .RST(RST), .P_DATA(pd_c), .data_valid(dv_c),
        .ready(rdy_c), .tick(tk_c), .ser_data(sd_c),
        .ser_busy(bsy_c), .ser_done(dn_c), .par_bit(par_c)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [7:0] w;
        logic [4:0] w5;

        RST  = 1'b1;
        pd_a = '0; dv_a = 0; tk_a = 0;
        pd_b = '0; dv_b = 0; tk_b = 0;
        pd_c = '0; dv_c = 0; tk_c = 0;
        #2 RST = 1'b0;
        #1;
        chk("rst_ready", rdy_a, 1);
        chk("rst_busy",  bsy_a, 0);
        chk("rst_ser",   sd_a,  1);
        chk("rst_done",  dn_a,  0);
        chk("rst_par",   par_a, 0);
        chk("rst_ser_b", sd_b,  1);
        chk("rst_rdy_c", rdy_c, 1);
        step();
        step();
        RST = 1'b1;

        // 0xA5 MSB first, tick every cycle
        w = 8'hA5;
        pd_a = w; dv_a = 1;
        step();
        dv_a = 0;
        chk("a5_busy", bsy_a, 1);
        chk("a5_rdy",  rdy_a, 0);
        chk("a5_b7",   sd_a,  w[7]);
        chk("a5_par",  par_a, 0);
        tk_a = 1;
        for (int i = 1; i < 8; i++) begin
            step();
            chk($sformatf("a5_b%0d", 7 - i), sd_a, w[7-i]);
            chk("a5_nodone", dn_a, 0);
        end
        step();
        chk("a5_done", dn_a,  1);
        chk("a5_rdy2", rdy_a, 1);
        chk("a5_idle", sd_a,  1);
        chk("a5_bsy0", bsy_a, 0);
        tk_a = 0;
        step();
        chk("a5_done_w", dn_a, 0);

        // tick with load in IDLE: load only
        w = 8'h40;
        pd_a = w; dv_a = 1; tk_a = 1;
        step();
        dv_a = 0; tk_a = 0;
        chk("lt_b7",   sd_a,  0);
        chk("lt_busy", bsy_a, 1);
        step();
        step();
        chk("lt_hold", sd_a, 0);
        tk_a = 1;
        for (int i = 1; i < 8; i++) begin
            step();
            chk($sformatf("lt_b%0d", 7 - i), sd_a, w[7-i]);
        end
        step();
        chk("lt_done", dn_a, 1);
        tk_a = 0;

        // back-to-back 0x3C then 0xC3, P_DATA disturbed mid-word
        w = 8'h3C;
        pd_a = w; dv_a = 1;
        step();
        pd_a = 8'hFF; tk_a = 1;
        chk("bb_b7", sd_a, w[7]);
        for (int i = 1; i < 8; i++) begin
            step();
            chk($sformatf("bb_b%0d", 7 - i), sd_a, w[7-i]);
        end
        step();
        chk("bb_done", dn_a, 1);
        pd_a = 8'hC3; tk_a = 0;
        step();
        dv_a = 0;
        w = 8'hC3;
        chk("bb2_busy", bsy_a, 1);
        chk("bb2_done", dn_a,  0);
        chk("bb2_b7",   sd_a,  w[7]);
        tk_a = 1;
        for (int i = 1; i < 8; i++) begin
            step();
            chk($sformatf("bb2_b%0d", 7 - i), sd_a, w[7-i]);
        end
        step();
        chk("bb2_done2", dn_a, 1);
        tk_a = 0;

        // 0x01 LSB first, tick every 4th cycle
        pd_b = 8'h01; dv_b = 1;
        step();
        dv_b = 0;
        chk("lsb_b0",  sd_b,  1);
        chk("lsb_par", par_b, 1);
        for (int k = 1; k <= 8; k++) begin
            for (int j = 0; j < 3; j++) begin
                step();
                chk("lsb_hold", sd_b, (k == 1) ? 1 : 0);
                chk("lsb_busy", bsy_b, 1);
            end
            tk_b = 1;
            step();
            tk_b = 0;
            if (k < 8) begin
                chk("lsb_bit", sd_b, 0);
                chk("lsb_nodone", dn_b, 0);
            end
        end
        chk("lsb_done", dn_b, 1);
        step();
        chk("lsb_done_w", dn_b, 0);
        chk("lsb_idle",   sd_b, 1);

        // 5-bit odd parity
        w5 = 5'b10011;
        pd_c = w5; dv_c = 1;
        step();
        dv_c = 0;
        chk("w5_par", par_c, 0);
        chk("w5_b4",  sd_c,  w5[4]);
        tk_c = 1;
        for (int i = 1; i < 5; i++) begin
            step();
            chk($sformatf("w5_b%0d", 4 - i), sd_c, w5[4-i]);
            chk("w5_nodone", dn_c, 0);
        end
        step();
        chk("w5_done", dn_c, 1);
        step();
        chk("w5_t6_ser",  sd_c,  1);
        chk("w5_t6_busy", bsy_c, 0);
        chk("w5_t6_done", dn_c,  0);
        chk("w5_t6_par",  par_c, 0);
        tk_c = 0;

        // reset mid-word
        pd_a = 8'hFF; dv_a = 1;
        step();
        dv_a = 0; tk_a = 1;
        step();
        step();
        step();
        tk_a = 0;
        chk("ab_busy", bsy_a, 1);
        #2 RST = 1'b0;
        #1;
        chk("ab_ser",  sd_a,  1);
        chk("ab_busy0", bsy_a, 0);
        chk("ab_rdy",  rdy_a, 1);
        chk("ab_done", dn_a,  0);
        step();
        chk("ab_done2", dn_a, 0);
        RST = 1'b1;
        pd_a = 8'h00; dv_a = 1;
        step();
        dv_a = 0;
        chk("z_busy", bsy_a, 1);
        chk("z_b7",   sd_a,  0);
        tk_a = 1;
        for (int i = 1; i < 8; i++) begin
            step();
            chk("z_bit", sd_a, 0);
        end
        step();
        chk("z_done", dn_a, 1);
        tk_a = 0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
